// File: rtl/pll_pkg.sv
// Shared types and helpers for the DCO cell encoder: default code width, FSM states, slew-step clamp.
// Combinational helpers only; no state lives here.
package pll_pkg;

  localparam int PLL_CODE_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    SLEW  = 2'd2
  } dco_enc_state_t;

  // Magnitude of the next slew step: min(|diff|, max_step).
  function automatic int clamp_step(input int diff, input int max_step);
    int mag;
    mag = (diff < 0) ? -diff : diff;
    return (mag > max_step) ? max_step : mag;
  endfunction

endpackage

// File: rtl/dco_cell_encoder_therm_rotate.sv
// Combinational count -> CELLS-bit thermometer, rotated left by ptr (modulo CELLS).
// With ptr tied to zero this is the plain LSB-aligned thermometer.
module therm_rotate
  import pll_pkg::*;
#(
  parameter int CODE_SIZE = PLL_CODE_SIZE
) (
  input  logic [CODE_SIZE-1:0]        count,
  input  logic [CODE_SIZE-1:0]        ptr,
  output logic [(2**CODE_SIZE)-2:0]   cells
);

  localparam int CELLS = (2**CODE_SIZE) - 1;

  logic [CELLS-1:0]   therm;
  logic [2*CELLS-1:0] wide;

  always_comb begin
    therm = '0;
    for (int i = 0; i < CELLS; i++) begin
      therm[i] = (i < int'(count));
    end
    // Bits shifted past the top fold back to bit 0, giving a modulo-CELLS rotation.
    wide  = {{CELLS{1'b0}}, therm} << ptr;
    cells = wide[CELLS-1:0] | wide[2*CELLS-1:CELLS];
  end

endmodule

// File: rtl/dco_cell_encoder.sv
// Slews the applied DCO code toward the filter target by at most MAX_STEP per clk_ref and drives registered cell enables.
// Optional DCO_DWA_EN rotates the enabled cells with a data-weighted-averaging pointer.
module dco_cell_encoder
  import pll_pkg::*;
#(
  parameter int CODE_SIZE = PLL_CODE_SIZE,
  parameter int MAX_STEP  = 4
) (
  input  logic                        clk_ref,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [CODE_SIZE-1:0]        code_in,
  input  logic                        code_valid,
  output logic                        code_ready,
  output logic [(2**CODE_SIZE)-2:0]   cell_en,
  output logic [CODE_SIZE-1:0]        code_now,
  output logic                        settled
);

  localparam int CELLS = (2**CODE_SIZE) - 1;

  dco_enc_state_t           state_q, state_d;
  logic [CODE_SIZE-1:0]     target_q, target_d;
  logic [CODE_SIZE-1:0]     code_now_q, code_now_d;
  logic [CELLS-1:0]         cell_en_q, cell_en_d;
  logic [CELLS-1:0]         rot_cells;
  logic [CODE_SIZE-1:0]     rot_ptr;
  logic signed [CODE_SIZE:0] diff;
  logic [CODE_SIZE-1:0]     step;

  // One extra bit keeps the signed difference exact across the full 0..CELLS range.
  assign diff = $signed({1'b0, target_q}) - $signed({1'b0, code_now_q});
  assign step = CODE_SIZE'(clamp_step(int'(diff), MAX_STEP));

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    code_now_d = code_now_q;
    if (!enable) begin
      state_d    = IDLE;
      target_d   = '0;
      code_now_d = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = TRACK;
        TRACK: begin
          if (code_valid) begin
            target_d = code_in;
            if (code_in != code_now_q) state_d = SLEW;
          end
        end
        SLEW: begin
          if (diff > 0) code_now_d = code_now_q + step;
          else          code_now_d = code_now_q - step;
          if (code_now_d == target_q) state_d = TRACK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DCO_DWA_EN
  logic [CODE_SIZE-1:0] ptr_q, ptr_d;
  logic [CODE_SIZE:0]   ptr_sum;

  assign rot_ptr = ptr_q;

  always_comb begin
    ptr_d   = ptr_q;
    ptr_sum = {1'b0, ptr_q} + {1'b0, code_now_d};
    if (!enable) begin
      ptr_d = '0;
    end else if (state_q == TRACK || state_q == SLEW) begin
      ptr_d = (ptr_sum >= (CODE_SIZE+1)'(CELLS)) ? CODE_SIZE'(ptr_sum - (CODE_SIZE+1)'(CELLS))
                                                 : CODE_SIZE'(ptr_sum);
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign rot_ptr = '0;
`endif

  therm_rotate #(.CODE_SIZE(CODE_SIZE)) u_therm_rotate (
    .count (code_now_d),
    .ptr   (rot_ptr),
    .cells (rot_cells)
  );

  // Enables come from the same next-code value as code_now, so both registers always agree.
  assign cell_en_d = rot_cells;

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      code_now_q <= '0;
      cell_en_q  <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      code_now_q <= code_now_d;
      cell_en_q  <= cell_en_d;
    end
  end

  assign code_ready = (state_q == TRACK);
  assign settled    = (state_q == TRACK);
  assign code_now   = code_now_q;
  assign cell_en    = cell_en_q;

endmodule

// File: tb/tb_dco_cell_encoder.sv
// Scoreboard bench for dco_cell_encoder: expected outputs are queued as stimulus is applied and compared one cycle later.
module tb_dco_cell_encoder;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  code_in = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic [30:0] cell_en;
  logic [4:0]  code_now;
  logic        settled;

  dco_cell_encoder #(.CODE_SIZE(5), .MAX_STEP(4)) dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .enable     (enable),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .cell_en    (cell_en),
    .code_now   (code_now),
    .settled    (settled)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct packed {
    logic [4:0]  code;
    logic [30:0] cells;
    logic        rdy;
    logic        st;
  } obs_t;

  typedef struct {
    bit vld;
    int cin;
    bit en;
    bit rs;
    int code;
    bit rdy;
  } row_t;

  obs_t sb[$];
  obs_t got, want;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [30:0] th(input int n);
    logic [31:0] one;
    one = 32'd1;
    return 31'((one << n) - 32'd1);
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; code_valid = 1'b0; code_in = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      sb.push_back('{code: 5'd0, cells: 31'd0, rdy: (i == 2), st: (i == 2)});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
  endtask

  task automatic test_up_slew();
    row_t r[4] = '{'{1, 10, 1, 0, 0, 0}, '{0, 0, 1, 0, 4, 0},
                   '{0, 0, 1, 0, 8, 0},  '{0, 0, 1, 0, 10, 1}};
    foreach (r[i]) begin
      code_valid = r[i].vld; code_in = 5'(r[i].cin); enable = r[i].en; rst = r[i].rs;
      sb.push_back('{code: 5'(r[i].code), cells: th(r[i].code), rdy: r[i].rdy, st: r[i].rdy});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL up_slew[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
  endtask

  task automatic test_down_slew();
    row_t r[11] = '{'{1, 31, 1, 0, 10, 0}, '{0, 0, 1, 0, 14, 0}, '{0, 0, 1, 0, 18, 0},
                    '{0, 0, 1, 0, 22, 0},  '{0, 0, 1, 0, 26, 0}, '{0, 0, 1, 0, 30, 0},
                    '{0, 0, 1, 0, 31, 1},  '{1, 20, 1, 0, 31, 0}, '{0, 0, 1, 0, 27, 0},
                    '{0, 0, 1, 0, 23, 0},  '{0, 0, 1, 0, 20, 1}};
    foreach (r[i]) begin
      code_valid = r[i].vld; code_in = 5'(r[i].cin); enable = r[i].en; rst = r[i].rs;
      sb.push_back('{code: 5'(r[i].code), cells: th(r[i].code), rdy: r[i].rdy, st: r[i].rdy});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL down_slew[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
  endtask

  task automatic test_handshake_ignore();
    row_t r[7] = '{'{1, 0, 1, 0, 20, 0}, '{1, 5, 1, 0, 16, 0}, '{1, 5, 1, 0, 12, 0},
                   '{1, 5, 1, 0, 8, 0},  '{1, 5, 1, 0, 4, 0},  '{1, 5, 1, 0, 0, 1},
                   '{0, 0, 1, 0, 0, 1}};
    foreach (r[i]) begin
      code_valid = r[i].vld; code_in = 5'(r[i].cin); enable = r[i].en; rst = r[i].rs;
      sb.push_back('{code: 5'(r[i].code), cells: th(r[i].code), rdy: r[i].rdy, st: r[i].rdy});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hs_ignore[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
  endtask

  task automatic test_enable_drop();
    row_t r[9] = '{'{1, 20, 1, 0, 0, 0}, '{0, 0, 1, 0, 4, 0}, '{0, 0, 1, 0, 8, 0},
                   '{0, 0, 0, 0, 0, 0},  '{0, 0, 1, 0, 0, 1}, '{0, 0, 1, 0, 0, 1},
                   '{1, 9, 0, 0, 0, 0},  '{0, 0, 1, 0, 0, 1}, '{0, 0, 1, 0, 0, 1}};
    foreach (r[i]) begin
      code_valid = r[i].vld; code_in = 5'(r[i].cin); enable = r[i].en; rst = r[i].rs;
      sb.push_back('{code: 5'(r[i].code), cells: th(r[i].code), rdy: r[i].rdy, st: r[i].rdy});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_drop[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
  endtask

  task automatic test_rst_mid_slew();
    row_t r[5] = '{'{1, 12, 1, 0, 0, 0}, '{0, 0, 1, 0, 4, 0}, '{0, 0, 1, 1, 0, 0},
                   '{0, 0, 1, 0, 0, 1},  '{0, 0, 1, 0, 0, 1}};
    foreach (r[i]) begin
      code_valid = r[i].vld; code_in = 5'(r[i].cin); enable = r[i].en; rst = r[i].rs;
      sb.push_back('{code: 5'(r[i].code), cells: th(r[i].code), rdy: r[i].rdy, st: r[i].rdy});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rst_mid_slew[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t r[7] = '{'{1, 3, 1, 0, 0, 0}, '{0, 0, 1, 0, 3, 1}, '{1, 1, 1, 0, 3, 0},
                   '{0, 0, 1, 0, 1, 1}, '{1, 1, 1, 0, 1, 1}, '{1, 0, 1, 0, 1, 0},
                   '{0, 0, 1, 0, 0, 1}};
    foreach (r[i]) begin
      code_valid = r[i].vld; code_in = 5'(r[i].cin); enable = r[i].en; rst = r[i].rs;
      sb.push_back('{code: 5'(r[i].code), cells: th(r[i].code), rdy: r[i].rdy, st: r[i].rdy});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
    code_valid = 1'b0;
  endtask

  task automatic test_dwa();
    logic [30:0] exp_cells [13] = '{31'h0, 31'h7, 31'h38, 31'h1C0, 31'hE00, 31'h7000,
                                    31'h38000, 31'h1C0000, 31'hE00000, 31'h7000000,
                                    31'h38000000, 31'h40000003, 31'h1C};
    for (int i = 0; i < 13; i++) begin
      code_valid = (i == 0); code_in = 5'd3; enable = 1'b1; rst = 1'b0;
      sb.push_back('{code: (i == 0) ? 5'd0 : 5'd3, cells: exp_cells[i], rdy: (i != 0), st: (i != 0)});
      @(posedge clk_ref); #1;
      got  = {code_now, cell_en, code_ready, settled};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL dwa[%0d]: got code=%0d cells=%h rdy=%b settled=%b, expected code=%0d cells=%h rdy=%b settled=%b",
                 i, got.code, got.cells, got.rdy, got.st, want.code, want.cells, want.rdy, want.st);
      end
    end
    code_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_ref);
    #1;
    test_reset();
`ifdef DCO_DWA_EN
    test_dwa();
`else
    test_up_slew();
    test_down_slew();
    test_handshake_ignore();
    test_enable_drop();
    test_rst_mid_slew();
    test_back_to_back();
`endif
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
